// File: rtl/serial_adder_ctrl_if.sv
// Start/ready/done handshake bundle for the bit-serial add/subtract sequencer.
// The master drives the request and operands; the slave returns the result and flags.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output start, a, b, cin, sub,
      input  ready, done, sum, cout, overflow, zero
   );

   modport slave (
      input  start, a, b, cin, sub,
      output ready, done, sum, cout, overflow, zero
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract built around a single full adder.
// Operands shift out LSB-first; the carry lives in a flip-flop between bits.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_adder_ctrl_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] sa_reg, sa_next;
   logic [WIDTH-1:0] sb_reg, sb_next;
   logic [WIDTH-1:0] res_reg, res_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             carry_reg, carry_next;
   logic             cmsb_reg, cmsb_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic             cout_reg, cout_next;
   logic             ovf_reg, ovf_next;
   logic             zero_reg, zero_next;

   logic [WIDTH-1:0] sb_load;
   logic [WIDTH-1:0] res_shift;
   logic             fa_s;
   logic             fa_co;

   // Subtraction loads the ones' complement of B; the +1 comes from the carry seed.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sb_load
         assign sb_load[gi] = bus.b[gi] ^ bus.sub;
      end
   endgenerate

   full_adder u_fa (
      .a  (sa_reg[0]),
      .b  (sb_reg[0]),
      .ci (carry_reg),
      .s  (fa_s),
      .co (fa_co)
   );

   assign res_shift = {fa_s, res_reg[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         sa_reg    <= '0;
         sb_reg    <= '0;
         res_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         cmsb_reg  <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         zero_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         sa_reg    <= sa_next;
         sb_reg    <= sb_next;
         res_reg   <= res_next;
         cnt_reg   <= cnt_next;
         carry_reg <= carry_next;
         cmsb_reg  <= cmsb_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
         ovf_reg   <= ovf_next;
         zero_reg  <= zero_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sa_next    = sa_reg;
      sb_next    = sb_reg;
      res_next   = res_reg;
      cnt_next   = cnt_reg;
      carry_next = carry_reg;
      cmsb_next  = cmsb_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      ovf_next   = ovf_reg;
      zero_next  = zero_reg;
      bus.ready  = 1'b0;
      bus.done   = 1'b0;

      case (state_reg)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) begin
               sa_next    = bus.a;
               sb_next    = sb_load;
               carry_next = bus.sub ? 1'b1 : bus.cin;
               cnt_next   = '0;
               res_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            res_next   = res_shift;
            sa_next    = sa_reg >> 1;
            sb_next    = sb_reg >> 1;
            carry_next = fa_co;
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == CNT_MSB) begin
               cmsb_next = fa_co;
            end
            if (cnt_reg == CNT_LAST) begin
               sum_next   = res_shift;
               cout_next  = fa_co;
               ovf_next   = cmsb_reg ^ fa_co;
               zero_next  = (res_shift == '0);
               state_next = DONE;
            end
         end
         DONE: begin
            bus.done   = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.sum      = sum_reg;
   assign bus.cout     = cout_reg;
   assign bus.overflow = ovf_reg;
   assign bus.zero     = zero_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 with hand-computed results.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Counts cycles from the accept edge (cycle 0) until done is seen, bounded.
   task automatic wait_done(output int n);
      n = 1;
      while (bus.done !== 1'b1 && n < 30) begin
         step();
         n++;
      end
   endtask

   // Drives one request from IDLE, accepts it, then waits for completion.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, output int n);
      bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.a = ~a; bus.b = ~b;
      wait_done(n);
      $display("op a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d zero=%0d lat=%0d",
               a, b, cin, sub, bus.sum, bus.cout, bus.overflow, bus.zero, n);
   endtask

   initial begin
      int n;
      int pulses;
      logic [W-1:0] seen_sum;

      compared   = 0;
      mismatched = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

      // Reset and idle
      step(); step();
      rst = 1'b0;
      check("rst_ready", {31'd0, bus.ready}, 32'd1);
      check("rst_done",  {31'd0, bus.done}, 32'd0);
      check("rst_sum",   {24'd0, bus.sum}, 32'h00);
      check("rst_flags", {29'd0, bus.cout, bus.overflow, bus.zero}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.done === 1'b1) pulses++;
      end
      check("idle_no_done", pulses, 0);
      $display("reset/idle: 20 idle cycles, done pulses=%0d", pulses);

      // Add with carry
      run_op(8'h5A, 8'h3C, 1'b1, 1'b0, n);
      check("add_latency", n, 9);
      check("add_sum",  {24'd0, bus.sum}, 32'h97);
      check("add_cout", {31'd0, bus.cout}, 32'd0);
      check("add_ovf",  {31'd0, bus.overflow}, 32'd1);
      check("add_zero", {31'd0, bus.zero}, 32'd0);
      check("add_ready_in_done", {31'd0, bus.ready}, 32'd0);
      step();
      check("add_done_one_cycle", {31'd0, bus.done}, 32'd0);
      check("add_ready_back", {31'd0, bus.ready}, 32'd1);

      // Wrap to zero
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, n);
      step();
      check("wrap_sum",  {24'd0, bus.sum}, 32'h00);
      check("wrap_cout", {31'd0, bus.cout}, 32'd1);
      check("wrap_ovf",  {31'd0, bus.overflow}, 32'd0);
      check("wrap_zero", {31'd0, bus.zero}, 32'd1);

      run_op(8'h7F, 8'h01, 1'b0, 1'b0, n);
      step();
      check("pos_ovf_sum", {24'd0, bus.sum}, 32'h80);
      check("pos_ovf_ovf", {31'd0, bus.overflow}, 32'd1);
      check("pos_ovf_cout", {31'd0, bus.cout}, 32'd0);

      // Subtract; cin must be ignored
      run_op(8'h10, 8'h20, 1'b1, 1'b1, n);
      step();
      check("sub_sum",  {24'd0, bus.sum}, 32'hF0);
      check("sub_cout", {31'd0, bus.cout}, 32'd0);
      check("sub_ovf",  {31'd0, bus.overflow}, 32'd0);

      run_op(8'h80, 8'h01, 1'b0, 1'b1, n);
      step();
      check("sub_ovf_sum",  {24'd0, bus.sum}, 32'h7F);
      check("sub_ovf_ovf",  {31'd0, bus.overflow}, 32'd1);
      check("sub_ovf_cout", {31'd0, bus.cout}, 32'd1);

      // Busy rejection and output stability
      bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step(); step();
      check("busy_ready_low", {31'd0, bus.ready}, 32'd0);
      bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("busy_sum_stable", {24'd0, bus.sum}, 32'h7F);
      pulses = 0;
      seen_sum = '0;
      for (int c = 4; c < 13; c++) begin
         if (bus.done === 1'b1) begin
            pulses++;
            seen_sum = bus.sum;
         end else if (c < 9) begin
            check("busy_sum_hold", {24'd0, bus.sum}, 32'h7F);
         end
         step();
      end
      check("busy_one_done", pulses, 1);
      check("busy_sum", {24'd0, seen_sum}, 32'h02);
      $display("busy: done pulses=%0d sum=%02h", pulses, seen_sum);

      // start held high: back-to-back ops sampled in IDLE
      bus.a = 8'h11; bus.b = 8'h22; bus.start = 1'b1;
      step();
      bus.a = 8'hEE; bus.b = 8'hEE;
      wait_done(n);
      check("b2b1_latency", n, 9);
      check("b2b1_sum", {24'd0, bus.sum}, 32'h33);
      $display("b2b op1: sum=%02h lat=%0d", bus.sum, n);
      bus.a = 8'h05; bus.b = 8'h06;
      step();
      check("b2b_idle_ready", {31'd0, bus.ready}, 32'd1);
      step();
      bus.start = 1'b0;
      wait_done(n);
      check("b2b2_latency", n, 9);
      check("b2b2_sum", {24'd0, bus.sum}, 32'h0B);
      $display("b2b op2: sum=%02h lat=%0d", bus.sum, n);
      step();

      // Reset mid-operation
      bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_ready", {31'd0, bus.ready}, 32'd1);
      check("abort_sum",   {24'd0, bus.sum}, 32'h00);
      check("abort_flags", {29'd0, bus.cout, bus.overflow, bus.zero}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1) pulses++;
         step();
      end
      check("abort_no_done", pulses, 0);
      $display("abort: done pulses after reset=%0d", pulses);
      run_op(8'h01, 8'h02, 1'b0, 1'b0, n);
      check("after_abort_latency", n, 9);
      check("after_abort_sum", {24'd0, bus.sum}, 32'h03);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract sequencer built around one full_adder instance.
- Feeds operand bits LSB-first through the single full_adder and holds the carry in a flip-flop between bits.
- Assembles the result in a shift register and reports flags.
- Gives the Never8 datapath an area-cheap WIDTH-bit adder behind a start/ready/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request. Sampled only when ready=1.
- a  input  WIDTH  operand A. Captured on accept.
- b  input  WIDTH  operand B. Captured on accept.
- cin  input  1  carry-in for add. Captured on accept. Ignored when sub=1.
- sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1). Captured on accept.
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result. Holds until the next completion.
- cout  output  1  carry out of the MSB. For sub, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

Behaviour:
- Reset: clk and rst only; synchronous, active-high.
  - On a rst-high clock edge: state=IDLE, ready=1, done=0, sum=0, cout=0, overflow=0, zero=0, bit counter=0, carry FF=0.
  - rst has priority over every other event, including mid-RUN. An aborted operation never asserts done, and sum/flags read 0 afterwards.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - Accept on a clock edge with start=1:
    - latch A into shift register SA, and (sub ? ~b : b) into SB;
    - carry FF <= sub ? 1 : cin;
    - counter <= 0; clear the result shift register;
    - go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - ready=0.
  - Each cycle the full_adder sees SA[0], SB[0] and the carry FF.
  - At the clock edge: s shifts into the result MSB (result >> 1); SA and SB shift right; carry FF <= full_adder cout; counter increments.
  - On the edge where counter == WIDTH-2, also latch the full_adder cout as carry-into-MSB for the overflow calculation.
  - On the edge where counter == WIDTH-1: go to DONE and update the outputs. sum <= final result; cout <= final carry; overflow <= carry-into-MSB XOR final carry; zero <= (final result == 0).
- DONE:
  - done=1 for exactly one cycle, ready=0.
  - Unconditionally return to IDLE the next edge.
- Latency: accept edge at cycle 0. RUN occupies cycles 1..WIDTH. done is high during cycle WIDTH+1. ready returns at cycle WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- Handshake rules:
  - start while ready=0 is ignored, not queued.
  - Input changes after accept have no effect.
  - start held high continuously gives back-to-back operations, each re-sampled in IDLE.
- Output stability: sum and the flags change only on the RUN→DONE edge or on reset. They are stable while a new operation is in RUN.
- Arithmetic: results are modulo 2^WIDTH. No saturation.

Test Plan:
- Reset then idle, WIDTH=8: rst high 2 cycles, then low -> ready=1, done=0, sum=0x00, all flags 0. done stays 0 for 20 idle cycles.
- Add with carry: a=0x5A, b=0x3C, cin=1, sub=0, start for one cycle -> done exactly 9 cycles after accept. sum=0x97, cout=0, overflow=1, zero=0.
- Wrap/zero: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, overflow=0, zero=1. Also a=0x7F, b=0x01 -> sum=0x80, overflow=1.
- Subtract: a=0x10, b=0x20, sub=1, cin=1 (ignored) -> sum=0xF0, cout=0 (borrow), overflow=0. Also a=0x80, b=0x01 -> sum=0x7F, overflow=1, cout=1.
- Busy rejection and stability: start a=0x01, b=0x01. Pulse start with a=0xAA, b=0x55 at cycle 3 of RUN -> only one done, sum=0x02. The previous sum stays unchanged until the RUN→DONE edge. Then start held high -> second op completes with its IDLE-sampled operands.
- Reset mid-operation: accept a=0x12, b=0x34, assert rst at cycle 4 of RUN -> next cycle ready=1, sum=0, no done pulse. A new op a=0x01, b=0x02 then yields sum=0x03.
